// File: rtl/fir_coeff_reload_ctrl.sv
// ----------------------------------------------------------------------------
// fir_coeff_reload_ctrl
//   Sequences a full coefficient reload of the 4-phase FIR trigger filter:
//   pulses coeff_areset, copies 16 x 64-bit words (4 phases x 4 addresses)
//   from the slow-control bank into the FIR, optionally reads each word back
//   and compares it, then restarts the baseline sum and waits for the filter
//   to produce valid output again. While a reload runs it owns the FIR coeff_*
//   inputs, bsum_reset and the valid_in gate (valid_en).
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start, abort            begin reload (1-cycle pulse) / abandon reload
//   bank_req/idx/ack/data   coefficient bank read handshake, idx = {phase, adr}
//   coeff_areset            FIR coeff_in_areset
//   coeff_we/adr/wdata      one-hot phase write enable, address, write data
//   coeff_read              readback strobe
//   coeff_rvalid/rdata      per-phase readback valid, readback data
//   valid_en                gate ANDed with sample valid into the FIR
//   bsum_reset              FIR baseline-sum restart
//   fvalid                  FIR output valid
//   busy, done              reload in progress / 1-cycle completion pulse
//   err, err_code, err_idx  sticky error (1=verify 2=timeout 3=abort), word idx
// ----------------------------------------------------------------------------
module fir_coeff_reload_ctrl #(
    parameter int AR_LEN         = 4,
    parameter int VERIFY         = 1,
    parameter int RD_TIMEOUT     = 63,
    parameter int SETTLE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        bank_req,
    output logic [3:0]  bank_idx,
    input  logic        bank_ack,
    input  logic [63:0] bank_data,
    output logic        coeff_areset,
    output logic [3:0]  coeff_we,
    output logic [1:0]  coeff_adr,
    output logic [63:0] coeff_wdata,
    output logic        coeff_read,
    input  logic [3:0]  coeff_rvalid,
    input  logic [63:0] coeff_rdata,
    output logic        valid_en,
    output logic        bsum_reset,
    input  logic        fvalid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [3:0]  err_idx
);

    typedef enum logic [2:0] {
        IDLE, ARST, FETCH, WRITE, RDREQ, RDWAIT, BRST, SETTLE
    } state_t;

    localparam logic [1:0]  E_VERIFY  = 2'd1;
    localparam logic [1:0]  E_TIMEOUT = 2'd2;
    localparam logic [1:0]  E_ABORT   = 2'd3;
    localparam logic [15:0] AR_LAST   = 16'(AR_LEN - 1);
    localparam logic [8:0]  RD_LIM    = 9'(RD_TIMEOUT);
    localparam logic [8:0]  ST_LIM    = 9'(SETTLE_TIMEOUT);

    state_t      state;
    logic [3:0]  idx;
    logic [15:0] ar_cnt;
    logic [7:0]  tmo_cnt;

    logic [8:0]  tmo_nxt;
    logic        rv_hit;
    logic        err_hit;
    logic [1:0]  err_c;
    logic        step;

    // One extra bit so a limit of 255 is reachable from an 8-bit counter.
    assign tmo_nxt = {1'b0, tmo_cnt} + 9'd1;
    // Only the phase being verified matters; other rvalid bits are ignored.
    assign rv_hit  = coeff_rvalid[idx[1+2:2]];

    // Error detection. Abort outranks everything, including a simultaneous
    // ack/rvalid/fvalid, so it is tested first.
    always_comb begin
        err_hit = 1'b0;
        err_c   = 2'd0;
        if (state != IDLE && abort) begin
            err_hit = 1'b1;
            err_c   = E_ABORT;
        end else if (state == RDWAIT) begin
            if (rv_hit) begin
                if (coeff_rdata != coeff_wdata) begin
                    err_hit = 1'b1;
                    err_c   = E_VERIFY;
                end
            end else if (tmo_nxt == RD_LIM) begin
                err_hit = 1'b1;
                err_c   = E_TIMEOUT;
            end
        end else if (state == SETTLE) begin
            if (!fvalid && tmo_nxt == ST_LIM) begin
                err_hit = 1'b1;
                err_c   = E_TIMEOUT;
            end
        end
    end

    // Word finished: after the write when not verifying, or after a clean compare.
    assign step = ((state == WRITE) && (VERIFY == 0)) ||
                  ((state == RDWAIT) && rv_hit && !err_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= 4'd0;
            ar_cnt       <= 16'd0;
            tmo_cnt      <= 8'd0;
            bank_req     <= 1'b0;
            bank_idx     <= 4'd0;
            coeff_areset <= 1'b0;
            coeff_we     <= 4'd0;
            coeff_adr    <= 2'd0;
            coeff_wdata  <= 64'd0;
            coeff_read   <= 1'b0;
            valid_en     <= 1'b1;
            bsum_reset   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'd0;
            err_idx      <= 4'd0;
        end else begin
            done <= 1'b0;
            if (err_hit) begin
                // idx is never advanced past 15, so a settle timeout reports 15.
                state        <= IDLE;
                err          <= 1'b1;
                err_code     <= err_c;
                err_idx      <= idx;
                busy         <= 1'b0;
                valid_en     <= 1'b1;
                coeff_areset <= 1'b0;
                coeff_we     <= 4'd0;
                coeff_read   <= 1'b0;
                bank_req     <= 1'b0;
                bsum_reset   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state        <= ARST;
                            busy         <= 1'b1;
                            valid_en     <= 1'b0;
                            err          <= 1'b0;
                            err_code     <= 2'd0;
                            err_idx      <= 4'd0;
                            idx          <= 4'd0;
                            ar_cnt       <= 16'd0;
                            coeff_areset <= 1'b1;
                        end
                    end
                    ARST: begin
                        if (ar_cnt == AR_LAST) begin
                            coeff_areset <= 1'b0;
                            bank_req     <= 1'b1;
                            bank_idx     <= idx;
                            state        <= FETCH;
                        end else begin
                            ar_cnt <= ar_cnt + 16'd1;
                        end
                    end
                    FETCH: begin
                        if (bank_ack) begin
                            bank_req    <= 1'b0;
                            coeff_wdata <= bank_data;  // doubles as the compare reference
                            coeff_we    <= 4'b0001 << idx[3:2];
                            coeff_adr   <= idx[1:0];
                            state       <= WRITE;
                        end
                    end
                    WRITE: begin
                        coeff_we <= 4'd0;
                        if (VERIFY != 0) begin
                            coeff_read <= 1'b1;
                            coeff_adr  <= idx[1:0];
                            state      <= RDREQ;
                        end
                    end
                    RDREQ: begin
                        coeff_read <= 1'b0;
                        tmo_cnt    <= 8'd0;
                        state      <= RDWAIT;
                    end
                    RDWAIT: begin
                        if (!rv_hit) tmo_cnt <= tmo_nxt[7:0];
                    end
                    BRST: begin
                        // fvalid during the bsum_reset cycle itself is not sampled.
                        bsum_reset <= 1'b0;
                        tmo_cnt    <= 8'd0;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (fvalid) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_nxt[7:0];
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (step) begin
                    if (idx == 4'd15) begin
                        bsum_reset <= 1'b1;
                        valid_en   <= 1'b1;
                        state      <= BRST;
                    end else begin
                        idx      <= idx + 4'd1;
                        bank_idx <= idx + 4'd1;
                        bank_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_reload_ctrl.sv
module tb_fir_coeff_reload_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // instance A: VERIFY=1, instance B: VERIFY=0
    logic a_start = 0, a_abort = 0, b_start = 0, b_abort = 0;
    logic a_bank_req, b_bank_req, a_ack, b_ack;
    logic [3:0] a_bank_idx, b_bank_idx;
    logic [63:0] a_bank_data, b_bank_data;
    logic a_areset, b_areset, a_read, b_read;
    logic [3:0] a_we, b_we;
    logic [1:0] a_adr, b_adr;
    logic [63:0] a_wdata, b_wdata;
    logic [3:0] a_rvalid, b_rvalid;
    logic [63:0] a_rdata, b_rdata;
    logic a_valid_en, b_valid_en, a_bsum, b_bsum, a_fvalid, b_fvalid;
    logic a_busy, b_busy, a_done, b_done, a_err, b_err;
    logic [1:0] a_err_code, b_err_code;
    logic [3:0] a_err_idx, b_err_idx;

    fir_coeff_reload_ctrl #(.AR_LEN(4), .VERIFY(1), .RD_TIMEOUT(63), .SETTLE_TIMEOUT(255)) u_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort),
        .bank_req(a_bank_req), .bank_idx(a_bank_idx), .bank_ack(a_ack), .bank_data(a_bank_data),
        .coeff_areset(a_areset), .coeff_we(a_we), .coeff_adr(a_adr), .coeff_wdata(a_wdata),
        .coeff_read(a_read), .coeff_rvalid(a_rvalid), .coeff_rdata(a_rdata),
        .valid_en(a_valid_en), .bsum_reset(a_bsum), .fvalid(a_fvalid),
        .busy(a_busy), .done(a_done), .err(a_err), .err_code(a_err_code), .err_idx(a_err_idx));

    fir_coeff_reload_ctrl #(.AR_LEN(4), .VERIFY(0), .RD_TIMEOUT(63), .SETTLE_TIMEOUT(255)) u_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
        .bank_req(b_bank_req), .bank_idx(b_bank_idx), .bank_ack(b_ack), .bank_data(b_bank_data),
        .coeff_areset(b_areset), .coeff_we(b_we), .coeff_adr(b_adr), .coeff_wdata(b_wdata),
        .coeff_read(b_read), .coeff_rvalid(b_rvalid), .coeff_rdata(b_rdata),
        .valid_en(b_valid_en), .bsum_reset(b_bsum), .fvalid(b_fvalid),
        .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code), .err_idx(b_err_idx));

    // bank: word idx reads as idx * 0x0101010101010101, ack one cycle after req
    assign a_bank_data = {8{{4'h0, a_bank_idx}}};
    assign b_bank_data = {8{{4'h0, b_bank_idx}}};
    assign b_rvalid = 4'd0;
    assign b_rdata  = 64'd0;
    assign b_fvalid = 1'b0;

    function automatic logic [1:0] oh2bin(input logic [3:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction

    // FIR model for A: echoes the last written word, with fault injection
    logic corrupt_en = 0, hang_en = 0;
    logic [3:0] corrupt_idx = 0, hang_idx = 0;
    logic [63:0] a_last_word;
    logic [3:0] a_last_idx;
    logic [7:0] a_fv_cnt;
    assign a_fvalid = (a_fv_cnt == 8'd10);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_ack <= 0; b_ack <= 0; a_rvalid <= 0; a_rdata <= 0;
            a_last_word <= 0; a_last_idx <= 0; a_fv_cnt <= 0;
        end else begin
            a_ack <= a_bank_req & ~a_ack;
            b_ack <= b_bank_req & ~b_ack;
            if (|a_we) begin
                a_last_word <= a_wdata;
                a_last_idx  <= {oh2bin(a_we), a_adr};
            end
            a_rvalid <= 4'd0;
            if (a_read && !(hang_en && a_last_idx == hang_idx)) begin
                a_rvalid <= 4'b0001 << a_last_idx[3:2];
                a_rdata  <= a_last_word ^ ((corrupt_en && a_last_idx == corrupt_idx) ? 64'd1 : 64'd0);
            end
            if (a_bsum) a_fv_cnt <= 8'd1;
            else if (a_fv_cnt != 0 && a_fv_cnt < 8'd20) a_fv_cnt <= a_fv_cnt + 8'd1;
        end
    end

    // monitors: observed writes land in arrays, event counters
    logic clr = 0;
    int cyc = 0;
    logic [69:0] obs_a [0:63];
    logic [69:0] obs_b [0:63];
    int a_nwr, a_nrd, a_nbs, a_nar, a_ndone, b_nwr, b_nrd, b_nbs, b_ndone;
    int a_rd_cyc, a_err_cyc, b_bs_cyc, b_err_cyc;
    logic a_err_q = 0, b_err_q = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            a_nwr <= 0; a_nrd <= 0; a_nbs <= 0; a_nar <= 0; a_ndone <= 0;
            b_nwr <= 0; b_nrd <= 0; b_nbs <= 0; b_ndone <= 0;
        end else begin
            if (|a_we && a_nwr < 64) begin obs_a[a_nwr] <= {a_we, a_adr, a_wdata}; a_nwr <= a_nwr + 1; end
            if (|b_we && b_nwr < 64) begin obs_b[b_nwr] <= {b_we, b_adr, b_wdata}; b_nwr <= b_nwr + 1; end
            if (a_read) a_nrd <= a_nrd + 1;
            if (b_read) b_nrd <= b_nrd + 1;
            if (a_bsum) a_nbs <= a_nbs + 1;
            if (b_bsum) b_nbs <= b_nbs + 1;
            if (a_areset) a_nar <= a_nar + 1;
            if (a_done) a_ndone <= a_ndone + 1;
            if (b_done) b_ndone <= b_ndone + 1;
        end
        if (a_read) a_rd_cyc <= cyc;     // edge entering RDWAIT
        if (b_bsum) b_bs_cyc <= cyc;     // edge entering SETTLE
        if (a_err && !a_err_q) a_err_cyc <= cyc - 1;  // edge that set err
        if (b_err && !b_err_q) b_err_cyc <= cyc - 1;
        a_err_q <= a_err;
        b_err_q <= b_err;
    end

    wire [17:0] a_outs = {a_busy, a_done, a_err, a_err_code, a_err_idx, a_bank_req,
                          a_areset, a_we, a_read, a_bsum, a_valid_en};
    wire [17:0] b_outs = {b_busy, b_done, b_err, b_err_code, b_err_idx, b_bank_req,
                          b_areset, b_we, b_read, b_bsum, b_valid_en};

    int n_chk = 0, n_pass = 0;
    int rd_a = 0, rd_b = 0;
    logic [69:0] exp_a [$];
    logic [69:0] exp_b [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1; tick(); clr = 0;
        rd_a = 0; rd_b = 0;
    endtask

    function automatic logic [69:0] exp_word(input int i);
        logic [3:0] k;
        k = 4'(i);
        return {4'b0001 << k[3:2], k[1:0], {8{{4'h0, k}}}};
    endfunction

    task automatic push_exp(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            if (b) exp_b.push_back(exp_word(i));
            else   exp_a.push_back(exp_word(i));
        end
    endtask

    task automatic drain(input bit b, input string t, input int n);
        logic [69:0] e, o;
        for (int i = 0; i < n; i++) begin
            if (b) begin e = exp_b.pop_front(); o = obs_b[rd_b]; rd_b++; end
            else   begin e = exp_a.pop_front(); o = obs_a[rd_a]; rd_a++; end
            chk($sformatf("%s_wr%0d_ctl", t, i), 64'(o[69:64]), 64'(e[69:64]));
            chk($sformatf("%s_wr%0d_dat", t, i), o[63:0], e[63:0]);
        end
        exp_a.delete(); exp_b.delete();
    endtask

    task automatic pulse_start(input bit b);
        if (b) b_start = 1; else a_start = 1;
        tick();
        a_start = 0; b_start = 0;
    endtask

    task automatic wait_idle(input bit b, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!(b ? b_busy : a_busy)) begin ok = 1; break; end
        end
    endtask

    task automatic wait_bank(input logic [3:0] ix, input bit need_ack, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (a_bank_req && a_bank_idx == ix && (!need_ack || a_ack)) begin ok = 1; break; end
        end
    endtask

    initial begin
        bit ok;
        repeat (3) tick();
        chk("rst_a_outs", 64'(a_outs), 64'h1);
        chk("rst_b_outs", 64'(b_outs), 64'h1);
        reset_n = 1;
        tick();
        chk("rst_a_idle", 64'(a_outs), 64'h1);

        // 1: clean reload with readback
        do_clr(); push_exp(0, 16); pulse_start(0);
        chk("t1_busy", 64'(a_busy), 64'd1);
        chk("t1_valid_en", 64'(a_valid_en), 64'd0);
        chk("t1_areset", 64'(a_areset), 64'd1);
        wait_idle(0, 1000, ok); tick();
        chk("t1_finished", 64'(ok), 64'd1);
        chk("t1_done_cnt", 64'(a_ndone), 64'd1);
        chk("t1_err", 64'(a_err), 64'd0);
        chk("t1_areset_cyc", 64'(a_nar), 64'd4);
        chk("t1_writes", 64'(a_nwr), 64'd16);
        chk("t1_reads", 64'(a_nrd), 64'd16);
        chk("t1_bsum", 64'(a_nbs), 64'd1);
        chk("t1_valid_en_end", 64'(a_valid_en), 64'd1);
        drain(0, "t1", 16);

        // 2: corrupted readback at idx 6
        corrupt_en = 1; corrupt_idx = 4'd6;
        do_clr(); push_exp(0, 7); pulse_start(0);
        wait_idle(0, 1000, ok); tick();
        chk("t2_finished", 64'(ok), 64'd1);
        chk("t2_err", 64'(a_err), 64'd1);
        chk("t2_code", 64'(a_err_code), 64'd1);
        chk("t2_idx", 64'(a_err_idx), 64'd6);
        chk("t2_bsum", 64'(a_nbs), 64'd0);
        chk("t2_done", 64'(a_ndone), 64'd0);
        chk("t2_valid_en", 64'(a_valid_en), 64'd1);
        chk("t2_writes", 64'(a_nwr), 64'd7);
        drain(0, "t2", 7);
        corrupt_en = 0;

        // 3: readback never returns at idx 9
        hang_en = 1; hang_idx = 4'd9;
        do_clr(); push_exp(0, 10); pulse_start(0);
        wait_idle(0, 1000, ok); tick();
        chk("t3_finished", 64'(ok), 64'd1);
        chk("t3_code", 64'(a_err_code), 64'd2);
        chk("t3_idx", 64'(a_err_idx), 64'd9);
        chk("t3_latency", 64'(a_err_cyc - a_rd_cyc), 64'd63);
        chk("t3_outs_off", 64'({a_bank_req, a_read, a_we, a_areset}), 64'd0);
        drain(0, "t3", 10);
        hang_en = 0;

        // 4: abort coincident with bank_ack at idx 3
        do_clr(); push_exp(0, 3); pulse_start(0);
        wait_bank(4'd3, 1'b1, 200, ok);
        chk("t4_reached", 64'(ok), 64'd1);
        a_abort = 1; tick(); a_abort = 0;
        chk("t4_code", 64'(a_err_code), 64'd3);
        chk("t4_idx", 64'(a_err_idx), 64'd3);
        chk("t4_busy", 64'(a_busy), 64'd0);
        chk("t4_bank_req", 64'(a_bank_req), 64'd0);
        tick();
        chk("t4_writes", 64'(a_nwr), 64'd3);
        chk("t4_no_write_now", 64'(a_we), 64'd0);
        drain(0, "t4", 3);
        // abort alone and start+abort while idle leave everything untouched
        a_abort = 1; tick(); a_abort = 0; tick();
        chk("t4_idle_abort", 64'({a_busy, a_err, a_err_code}), 64'h7);
        a_start = 1; a_abort = 1; tick(); a_start = 0; a_abort = 0; tick();
        chk("t4_start_abort", 64'({a_busy, a_err, a_err_code}), 64'h7);

        // 5: VERIFY=0, fvalid never arrives
        do_clr(); push_exp(1, 16); pulse_start(1);
        wait_idle(1, 1000, ok); tick();
        chk("t5_finished", 64'(ok), 64'd1);
        chk("t5_writes", 64'(b_nwr), 64'd16);
        chk("t5_reads", 64'(b_nrd), 64'd0);
        chk("t5_bsum", 64'(b_nbs), 64'd1);
        chk("t5_code", 64'(b_err_code), 64'd2);
        chk("t5_idx", 64'(b_err_idx), 64'd15);
        chk("t5_latency", 64'(b_err_cyc - b_bs_cyc), 64'd255);
        chk("t5_done", 64'(b_ndone), 64'd0);
        drain(1, "t5", 16);

        // 6: second start ignored, reset mid-reload, then fresh reload
        do_clr(); push_exp(0, 16); pulse_start(0);
        wait_bank(4'd5, 1'b0, 200, ok);
        chk("t6_reach5", 64'(ok), 64'd1);
        pulse_start(0);
        wait_bank(4'd12, 1'b0, 400, ok);
        chk("t6_reach12", 64'(ok), 64'd1);
        reset_n = 0;
        #1;
        chk("t6_rst_a_outs", 64'(a_outs), 64'h1);
        chk("t6_areset_cyc", 64'(a_nar), 64'd4);
        tick(); tick();
        chk("t6_writes", 64'(a_nwr), 64'd12);
        drain(0, "t6a", 12);
        reset_n = 1;
        do_clr(); push_exp(0, 16); pulse_start(0);
        wait_idle(0, 1000, ok); tick();
        chk("t6_finished", 64'(ok), 64'd1);
        chk("t6_done", 64'(a_ndone), 64'd1);
        chk("t6_err", 64'(a_err), 64'd0);
        chk("t6_writes2", 64'(a_nwr), 64'd16);
        drain(0, "t6b", 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
